fetch_seq: RTL

//  Program-counter and instruction-fetch sequencer. It consumes the branch decision
//  (branch_o from the branch logic) and the jump target, then fetches from instruction

---
 rtl/fetch_seq.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/fetch_seq.sv
// -----------------------------------------------------------------------------
// fetch_seq - program-counter and instruction-fetch sequencer
//
// Holds the program counter and fetches one instruction at a time from
// instruction memory over a req/ack handshake. The fetched word goes to decode
// over a valid/ready handshake. A taken branch redirects the PC. If the branch
// arrives while a memory request is in flight, the request still completes and
// its data is dropped. At most one fetch is outstanding and there is no
// prefetch. All outputs come straight from registers.
//
// Ports
//   clk_i          in   1        clock, rising edge
//   rst_ni         in   1        asynchronous reset, active-low
//   branch_i       in   1        taken-branch strobe (one cycle per branch)
//   target_i       in   ADDR_W   branch target, valid with branch_i
//   stall_i        in   1        blocks issue of a new memory request (IDLE only)
//   mem_req_o      out  1        instruction memory request
//   mem_addr_o     out  ADDR_W   request address, stable while mem_req_o=1
//   mem_ack_i      in   1        memory acknowledge, mem_rdata_i valid same cycle
//   mem_rdata_i    in   INSTR_W  instruction read data
//   instr_o        out  INSTR_W  fetched instruction
//   instr_pc_o     out  ADDR_W   address of instr_o
//   instr_valid_o  out  1        instr_o / instr_pc_o valid
//   instr_ready_i  in   1        decode accepts instr_o
// -----------------------------------------------------------------------------
module fetch_seq #(
    parameter int unsigned              ADDR_W   = 8,
    parameter int unsigned              INSTR_W  = 8,
    parameter logic [ADDR_W-1:0]        RESET_PC = '0
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                branch_i,
    input  logic [ADDR_W-1:0]   target_i,
    input  logic                stall_i,
    output logic                mem_req_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    input  logic                mem_ack_i,
    input  logic [INSTR_W-1:0]  mem_rdata_i,
    output logic [INSTR_W-1:0]  instr_o,
    output logic [ADDR_W-1:0]   instr_pc_o,
    output logic                instr_valid_o,
    input  logic                instr_ready_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t               state_q,       state_d;
    logic [ADDR_W-1:0]    pc_q,          pc_d;
    logic                 mem_req_q,     mem_req_d;
    logic [ADDR_W-1:0]    mem_addr_q,    mem_addr_d;
    logic [INSTR_W-1:0]   instr_q,       instr_d;
    logic [ADDR_W-1:0]    instr_pc_q,    instr_pc_d;
    logic                 instr_valid_q, instr_valid_d;
    // Set when a branch redirected the PC while a request was in flight;
    // the data returned by that request belongs to the old path.
    logic                 flush_q,       flush_d;

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every register samples its next value from the same pre-edge snapshot.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= RESET_PC;
            instr_q       <= '0;
            instr_pc_q    <= RESET_PC;
            instr_valid_q <= 1'b0;
            flush_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            flush_q       <= flush_d;
        end
    end

    always_comb begin
        // NOTE: every signal written below gets its hold value first; a path
        // that leaves one unassigned would otherwise infer a latch.
        state_d       = state_q;
        pc_d          = pc_q;
        mem_req_d     = mem_req_q;
        mem_addr_d    = mem_addr_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        flush_d       = flush_q;

        unique case (state_q)
            IDLE: begin
                if (branch_i) begin
                    pc_d = target_i;
                end else if (!stall_i) begin
                    mem_addr_d = pc_q;
                    mem_req_d  = 1'b1;
                    state_d    = REQ;
                end
            end

            // mem_addr_q is never written here, which keeps the request
            // address stable for the whole handshake. stall_i is ignored.
            REQ: begin
                if (mem_ack_i) begin
                    mem_req_d = 1'b0;
                    if (flush_q || branch_i) begin
                        // Wrong-path data: discard it. The PC already holds
                        // the redirect target unless the branch is this cycle.
                        flush_d = 1'b0;
                        if (branch_i) begin
                            pc_d = target_i;
                        end
                        state_d = IDLE;
                    end else begin
                        instr_d       = mem_rdata_i;
                        instr_pc_d    = mem_addr_q;
                        instr_valid_d = 1'b1;
                        pc_d          = mem_addr_q + ADDR_W'(1);
                        state_d       = HOLD;
                    end
                end else if (branch_i) begin
                    // Let the request finish; a later branch simply
                    // overwrites the PC again.
                    pc_d    = target_i;
                    flush_d = 1'b1;
                end
            end

            // A branch beats instr_ready_i: the held word is off-path.
            HOLD: begin
                if (branch_i) begin
                    instr_valid_d = 1'b0;
                    pc_d          = target_i;
                    state_d       = IDLE;
                end else if (instr_ready_i) begin
                    instr_valid_d = 1'b0;
                    state_d       = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_req_o     = mem_req_q;
    assign mem_addr_o    = mem_addr_q;
    assign instr_o       = instr_q;
    assign instr_pc_o    = instr_pc_q;
    assign instr_valid_o = instr_valid_q;

endmodule
